// File: rtl/mux_tree_pipe_if.sv
// Stream bundle for mux_tree_pipe: parallel input lanes plus selector in,
// one selected word out, valid/ready on both sides.
interface mux_tree_pipe_if #(
    parameter int WIDTH = 8,
    parameter int N_IN  = 64
);
    localparam int LEVELS = $clog2(N_IN);

    logic [N_IN*WIDTH-1:0] in_data;
    logic [LEVELS-1:0]     in_sel;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      out_data;
    logic [LEVELS-1:0]     out_sel;
    logic                  out_err;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_err, out_valid
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_err, out_valid
    );
endinterface

// File: rtl/mux_tree_pipe.sv
// N:1 word multiplexer built as a binary tree of 2:1 levels, with an optional
// register slice after each level and bubble-collapsing valid/ready flow control.
module mux_tree_pipe #(
    parameter int WIDTH    = 8,
    parameter int N_IN     = 64,
    parameter int PIPELINE = 1
) (
    input  logic           clk,
    input  logic           rst,
    mux_tree_pipe_if.slave bus
);
    localparam int LEVELS = $clog2(N_IN);
    localparam int STAGES = (PIPELINE != 0) ? LEVELS : 1;
    localparam int NP     = 1 << LEVELS;
    localparam int WW     = NP * WIDTH;
    localparam int LAST   = STAGES - 1;
    localparam int SW     = LEVELS + 1;

    // One tree level: word i of the result is word 2i or 2i+1 of the input.
    // The upper half of the result is unused and tied to zero.
    function automatic logic [WW-1:0] level_mux(input logic [WW-1:0] w, input logic s);
        logic [WW-1:0] r;
        r = '0;
        for (int i = 0; i < NP / 2; i++) begin
            r[i*WIDTH +: WIDTH] = s ? w[(2*i+1)*WIDTH +: WIDTH] : w[(2*i)*WIDTH +: WIDTH];
        end
        return r;
    endfunction

    function automatic logic sel_err(input logic [LEVELS-1:0] sel);
        return {1'b0, sel} >= SW'(N_IN);
    endfunction

    logic [WW-1:0]     in_pad;
    logic [WW-1:0]     tree_w  [LEVELS+1];

    logic [STAGES-1:0] stg_vld;
    logic [STAGES-1:0] stg_err;
    logic [STAGES-1:0] stg_load;
    logic [STAGES:0]   adv;
    logic [WW-1:0]     stg_w   [STAGES];
    logic [LEVELS-1:0] stg_sel [STAGES];

    logic [STAGES-1:0] up_vld;
    logic [STAGES-1:0] up_err;
    logic [WW-1:0]     up_w    [STAGES];
    logic [LEVELS-1:0] up_sel  [STAGES];

    // Pad inputs can never be selected without raising err, so zero is safe.
    always_comb begin
        in_pad = '0;
        in_pad[N_IN*WIDTH-1:0] = bus.in_data;
    end

    assign tree_w[0] = in_pad;

    // Tree levels: each registered level reads the previous stage's words and
    // the selector that travelled with them; otherwise it chains combinationally.
    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        if (PIPELINE != 0 && l > 0) begin : g_reg
            assign tree_w[l+1] = level_mux(stg_w[l-1], stg_sel[l-1][l]);
        end else begin : g_comb
            assign tree_w[l+1] = level_mux(tree_w[l], bus.in_sel[l]);
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_up
        if (s == 0) begin : g_head
            assign up_vld[s] = bus.in_valid;
            assign up_sel[s] = bus.in_sel;
            assign up_err[s] = sel_err(bus.in_sel);
            assign up_w[s]   = tree_w[(PIPELINE != 0) ? 1 : LEVELS];
        end else begin : g_body
            assign up_vld[s] = stg_vld[s-1];
            assign up_sel[s] = stg_sel[s-1];
            assign up_err[s] = stg_err[s-1];
            assign up_w[s]   = tree_w[s+1];
        end
    end

    // A stage advances when it is empty or its successor advances; the
    // chain is driven only by register state and out_ready, never in_valid.
    always_comb begin
        adv         = '0;
        adv[STAGES] = bus.out_ready;
        for (int s = STAGES - 1; s >= 0; s--) begin
            adv[s] = !stg_vld[s] || adv[s+1];
        end
        stg_load = adv[STAGES-1:0];
    end

    assign bus.in_ready = stg_load[0];

    // Stage registers: valid bits reset; payload only captures real beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_vld <= '0;
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (stg_load[s]) stg_vld[s] <= up_vld[s];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < STAGES; s++) begin
            if (stg_load[s] && up_vld[s]) begin
                stg_w[s]   <= up_w[s];
                stg_sel[s] <= up_sel[s];
                stg_err[s] <= up_err[s];
            end
        end
    end

    // Output: payload is masked by valid so idle and reset cycles read as zero.
    assign bus.out_valid = stg_vld[LAST];
    assign bus.out_err   = stg_vld[LAST] && stg_err[LAST];
    assign bus.out_sel   = stg_vld[LAST] ? stg_sel[LAST] : '0;
    assign bus.out_data  = (stg_vld[LAST] && !stg_err[LAST]) ? stg_w[LAST][WIDTH-1:0] : '0;
endmodule

// File: tb/tb_mux_tree_pipe.sv
// Bench for mux_tree_pipe: a 64-input pipelined instance and a 5-input
// single-register instance, each checked against a queue model every cycle.
module tb_mux_tree_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mux_tree_pipe_if #(.WIDTH(8), .N_IN(64)) a_if ();
    mux_tree_pipe_if #(.WIDTH(8), .N_IN(5))  b_if ();

    mux_tree_pipe #(.WIDTH(8), .N_IN(64), .PIPELINE(1)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
    mux_tree_pipe #(.WIDTH(8), .N_IN(5),  .PIPELINE(0)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

    typedef struct packed {
        logic [7:0]  data;
        logic [5:0]  sel;
        logic        err;
        logic [31:0] t;
    } beat_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    int unsigned ncyc = 0;
    always @(posedge clk) ncyc <= ncyc + 1;

    beat_t       qa[$];
    beat_t       qb[$];
    bit          lat_a = 0, lat_b = 0;
    int          a_outs = 0, b_outs = 0;
    logic        a_stall = 0, b_stall = 0;
    logic [14:0] a_hold;
    logic [11:0] b_hold;

    // Model for the 64-input instance: every accepted beat is queued with the
    // word it must produce; every output transfer must match the queue head.
    always @(negedge clk) begin : mon_a
        beat_t e;
        if (rst) begin
            qa.delete();
            a_stall = 0;
        end else begin
            if (a_stall) begin
                check("a_stall_valid", 32'(a_if.out_valid), 1);
                check("a_stall_hold", 32'({a_if.out_err, a_if.out_sel, a_if.out_data}), 32'(a_hold));
            end
            if (a_if.out_valid && a_if.out_ready) begin
                if (qa.size() == 0) check("a_extra_beat", qa.size(), 1);
                else begin
                    e = qa.pop_front();
                    check("a_data", 32'(a_if.out_data), 32'(e.data));
                    check("a_sel", 32'(a_if.out_sel), 32'(e.sel));
                    check("a_err", 32'(a_if.out_err), 32'(e.err));
                    if (lat_a) check("a_latency", ncyc - e.t, 6);
                    a_outs++;
                end
            end
            if (a_if.in_valid && a_if.in_ready) begin
                e.sel = a_if.in_sel;
                e.err = int'(a_if.in_sel) >= 64;
                if (e.err) e.data = 8'h00;
                else       e.data = a_if.in_data[int'(a_if.in_sel)*8 +: 8];
                e.t = ncyc;
                qa.push_back(e);
            end
            a_stall = a_if.out_valid && !a_if.out_ready;
            a_hold  = {a_if.out_err, a_if.out_sel, a_if.out_data};
        end
    end

    always @(negedge clk) begin : mon_b
        beat_t e;
        if (rst) begin
            qb.delete();
            b_stall = 0;
        end else begin
            if (b_stall) begin
                check("b_stall_valid", 32'(b_if.out_valid), 1);
                check("b_stall_hold", 32'({b_if.out_err, b_if.out_sel, b_if.out_data}), 32'(b_hold));
            end
            if (b_if.out_valid && b_if.out_ready) begin
                if (qb.size() == 0) check("b_extra_beat", qb.size(), 1);
                else begin
                    e = qb.pop_front();
                    check("b_data", 32'(b_if.out_data), 32'(e.data));
                    check("b_sel", 32'(b_if.out_sel), 32'(e.sel));
                    check("b_err", 32'(b_if.out_err), 32'(e.err));
                    if (lat_b) check("b_latency", ncyc - e.t, 1);
                    b_outs++;
                end
            end
            if (b_if.in_valid && b_if.in_ready) begin
                e.sel = 6'(b_if.in_sel);
                e.err = int'(b_if.in_sel) >= 5;
                if (e.err) e.data = 8'h00;
                else       e.data = b_if.in_data[int'(b_if.in_sel)*8 +: 8];
                e.t = ncyc;
                qb.push_back(e);
            end
            b_stall = b_if.out_valid && !b_if.out_ready;
            b_hold  = {b_if.out_err, b_if.out_sel, b_if.out_data};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int sent;
        for (int k = 0; k < 64; k++) a_if.in_data[k*8 +: 8] = 8'(k + 'h40);
        for (int k = 0; k < 5; k++)  b_if.in_data[k*8 +: 8] = 8'('h11 * (k + 1));
        a_if.in_valid = 0; a_if.in_sel = '0; a_if.out_ready = 1;
        b_if.in_valid = 0; b_if.in_sel = '0; b_if.out_ready = 1;

        // Reset held for two edges
        rst = 1;
        repeat (2) tick();
        rst = 0;
        @(negedge clk);
        check("rst_a_valid", 32'(a_if.out_valid), 0);
        check("rst_a_data", 32'(a_if.out_data), 0);
        check("rst_a_sel", 32'(a_if.out_sel), 0);
        check("rst_a_err", 32'(a_if.out_err), 0);
        check("rst_a_in_ready", 32'(a_if.in_ready), 1);
        check("rst_b_valid", 32'(b_if.out_valid), 0);
        check("rst_b_data", 32'(b_if.out_data), 0);
        check("rst_b_in_ready", 32'(b_if.in_ready), 1);
        tick();

        // Sweep all 64 selects back-to-back
        lat_a = 1;
        base  = a_outs;
        for (int s = 0; s < 64; s++) begin
            a_if.in_valid = 1;
            a_if.in_sel   = 6'(s);
            tick();
            if (s == 5) begin
                check("sweep_first_valid", 32'(a_if.out_valid), 1);
                check("sweep_first_data", 32'(a_if.out_data), 32'h40);
                check("sweep_first_sel", 32'(a_if.out_sel), 0);
            end
            if (s == 15) check("sweep_beat10_data", 32'(a_if.out_data), 32'h4A);
            if (s == 63) check("sweep_beat58_data", 32'(a_if.out_data), 32'h7A);
        end
        a_if.in_valid = 0;
        repeat (6) tick();
        check("sweep_count", a_outs - base, 64);
        lat_a = 0;
        repeat (2) tick();

        // Backpressure: consumer stalls for cycles 3..12
        base = a_outs;
        sent = 0;
        for (int c = 0; c < 40; c++) begin
            a_if.in_valid  = sent < 10;
            a_if.in_sel    = 6'(20 + sent);
            a_if.out_ready = !(c >= 3 && c <= 12);
            @(negedge clk);
            if (c == 10) begin
                check("bp_in_ready_full", 32'(a_if.in_ready), 0);
                check("bp_out_valid", 32'(a_if.out_valid), 1);
                check("bp_out_data", 32'(a_if.out_data), 32'h54);
            end
            if (a_if.in_valid && a_if.in_ready) sent++;
            tick();
        end
        a_if.in_valid = 0;
        check("bp_count", a_outs - base, 10);

        // Bubbles: alternate valid with the consumer stalled, then release
        base = a_outs;
        a_if.out_ready = 0;
        for (int c = 0; c < 8; c++) begin
            a_if.in_valid = (c % 2) == 0;
            a_if.in_sel   = 6'(30 + c / 2);
            tick();
        end
        a_if.in_valid = 0;
        repeat (6) tick();
        @(negedge clk);
        check("bub_in_ready", 32'(a_if.in_ready), 1);
        check("bub_head_data", 32'(a_if.out_data), 32'h5E);
        tick();
        a_if.out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bub_burst_valid", 32'(a_if.out_valid), 1);
            check("bub_burst_data", 32'(a_if.out_data), 32'(8'h5E + 8'(k)));
            tick();
        end
        repeat (4) tick();
        check("bub_count", a_outs - base, 4);

        // Mid-stream reset with four beats in flight
        for (int c = 0; c < 4; c++) begin
            a_if.in_valid = 1;
            a_if.in_sel   = 6'(40 + c);
            tick();
        end
        a_if.in_valid = 0;
        rst = 1;
        tick();
        rst = 0;
        check("mrst_out_valid", 32'(a_if.out_valid), 0);
        check("mrst_in_ready", 32'(a_if.in_ready), 1);
        base = a_outs;
        for (int c = 0; c < 3; c++) begin
            a_if.in_valid = 1;
            a_if.in_sel   = 6'(50 + c);
            tick();
        end
        a_if.in_valid = 0;
        repeat (10) tick();
        check("mrst_count", a_outs - base, 3);

        // Range check on the 5-input, single-register instance
        lat_b = 1;
        base  = b_outs;
        b_if.out_ready = 1;
        for (int k = 0; k < 6; k++) begin
            int sv;
            sv = (k == 0) ? 5 : (k == 1) ? 6 : (k == 2) ? 7 : (k == 3) ? 4 : (k == 4) ? 0 : 3;
            b_if.in_valid = 1;
            b_if.in_sel   = 3'(sv);
            tick();
            if (k == 0) begin
                check("rng_sel5_valid", 32'(b_if.out_valid), 1);
                check("rng_sel5_err", 32'(b_if.out_err), 1);
                check("rng_sel5_data", 32'(b_if.out_data), 0);
                check("rng_sel5_sel", 32'(b_if.out_sel), 5);
            end
            if (k == 2) check("rng_sel7_err", 32'(b_if.out_err), 1);
            if (k == 3) begin
                check("rng_sel4_err", 32'(b_if.out_err), 0);
                check("rng_sel4_data", 32'(b_if.out_data), 32'h55);
            end
        end
        b_if.in_valid = 0;
        tick();
        lat_b = 0;
        check("rng_count", b_outs - base, 6);

        // Intermittent stalls on the single-register instance
        base = b_outs;
        for (int c = 0; c < 12; c++) begin
            b_if.in_valid  = c < 6;
            b_if.in_sel    = 3'(c);
            b_if.out_ready = (c % 3) != 1;
            @(negedge clk);
            if (c == 4) check("b_stall_in_ready", 32'(b_if.in_ready), 0);
            tick();
        end
        b_if.in_valid  = 0;
        b_if.out_ready = 1;
        repeat (3) tick();
        check("b_drain_queue", qb.size(), 0);
        check("a_drain_queue", qa.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
